// File: rtl/chirp_uart_tx.sv
// chirp_uart_tx -- UART transmitter with a small transmit FIFO.
// Frame: start bit, DATA_WIDTH data bits LSB first, stop bit (8N1 by default).
// Optional feature macro: CHIRP_UART_TX_PARITY_EN adds an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
// o_tx is registered: the next line level is computed together with the next
// state, so the line changes on the same edge the FSM changes state.
`timescale 1ns/1ps
module chirp_uart_tx #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy
);

  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  BIT_TIME_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST     = BIT_W'(DATA_WIDTH - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL     = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef CHIRP_UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

`ifdef CHIRP_UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  logic par_r;
  logic par_s;
`endif

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [BIT_W-1:0]        bit_r, bit_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_s;
  logic                    tx_r, tx_s;
  logic [DATA_WIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [FCNT_W-1:0]       count_r;
  logic                    push_s, pop_s, bit_end_s, fifo_nempty_s;
  logic [DATA_WIDTH-1:0]   head_s;

  assign o_ready       = (count_r < FIFO_FULL);
  assign push_s        = i_valid & o_ready;
  assign fifo_nempty_s = (count_r != {FCNT_W{1'b0}});
  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign bit_end_s     = (cnt_r == BIT_TIME_LAST);
  assign o_tx          = tx_r;
  assign o_busy        = (state_r != IDLE) || fifo_nempty_s;

  // FIFO storage: write the accepted byte at the write pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_mem_r <= '{default: {DATA_WIDTH{1'b0}}};
    end else if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= i_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {FCNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + FCNT_W'(1);
        2'b01:   count_r <= count_r - FCNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Transmit FSM state, bit timer, shift register and registered line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      shift_r <= {DATA_WIDTH{1'b0}};
      tx_r    <= 1'b1;
`ifdef CHIRP_UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
`ifdef CHIRP_UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  // Next state; the line level is chosen for the state being entered.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    pop_s   = 1'b0;
`ifdef CHIRP_UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        bit_s = {BIT_W{1'b0}};
        if (fifo_nempty_s) begin
          pop_s   = 1'b1;
          state_s = START;
          shift_s = head_s;
          tx_s    = 1'b0;
`ifdef CHIRP_UART_TX_PARITY_EN
          par_s   = even_parity(head_s);
`endif
        end else begin
          state_s = IDLE;
          tx_s    = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          cnt_s   = {CNT_W{1'b0}};
          bit_s   = {BIT_W{1'b0}};
          tx_s    = shift_r[0];
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_s = {CNT_W{1'b0}};
          if (bit_r == DATA_LAST) begin
            bit_s   = {BIT_W{1'b0}};
`ifdef CHIRP_UART_TX_PARITY_EN
            state_s = PARITY;
            tx_s    = par_r;
`else
            state_s = STOP;
            tx_s    = 1'b1;
`endif
          end else begin
            bit_s   = bit_r + BIT_W'(1);
            shift_s = shift_r >> 1;
            tx_s    = shift_r[1];
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
`ifdef CHIRP_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          cnt_s   = {CNT_W{1'b0}};
          tx_s    = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          cnt_s = {CNT_W{1'b0}};
          bit_s = {BIT_W{1'b0}};
          // Chain straight into the next frame when more data is queued.
          if (fifo_nempty_s) begin
            pop_s   = 1'b1;
            state_s = START;
            shift_s = head_s;
            tx_s    = 1'b0;
`ifdef CHIRP_UART_TX_PARITY_EN
            par_s   = even_parity(head_s);
`endif
          end else begin
            state_s = IDLE;
            tx_s    = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        bit_s   = {BIT_W{1'b0}};
        tx_s    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_chirp_uart_tx.sv
// Bench for chirp_uart_tx: table-driven single frames checked bit by bit,
// a receiving monitor feeding a scoreboard, hand sequences for back-to-back
// traffic / full FIFO / mid-frame reset, and a 9600 bps receiver model on a
// second instance running at CLKS_PER_BIT = 1042.
`timescale 1ns/1ps
module tb_chirp_uart_tx;
  localparam int C = 4;
`ifdef CHIRP_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int  SLOW_C = 1042;
  localparam real BIT_NS = 1.0e9 / 9600.0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy;
  logic [7:0] din_slow = 8'h00;
  logic       valid_slow = 1'b0;
  logic       ready_slow, tx_slow, busy_slow;

  always #50 clk = ~clk;  // 10 MHz

  chirp_uart_tx #(.CLKS_PER_BIT(C), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(valid),
    .o_ready(ready), .o_tx(tx), .o_busy(busy));

  chirp_uart_tx #(.CLKS_PER_BIT(SLOW_C), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut_slow (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din_slow), .i_valid(valid_slow),
    .o_ready(ready_slow), .o_tx(tx_slow), .o_busy(busy_slow));

  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] sb[$];
  int         frame_starts[$];
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] b);
    int w = 0;
    valid = 1'b1;
    din   = b;
    while (!ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      fail_now("push_ready");
      valid = 1'b0;
    end else begin
      @(posedge clk);
      sb.push_back(b);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    while (busy && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (busy) fail_now("wait_idle");
  endtask

  // Fast-line receiver: samples mid-bit, pops the scoreboard per frame.
  initial begin
    bit         rx_act = 1'b0;
    int         rx_cyc = 0;
    logic [10:0] rx_bits = 11'h7FF;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (tx === 1'b0) begin
          rx_act = 1'b1;
          rx_cyc = 0;
          frame_starts.push_back(cyc);
        end
      end else begin
        rx_cyc++;
      end
      if (rx_act && rst_n) begin
        if (rx_cyc % C == C / 2) rx_bits[rx_cyc / C] = tx;
        if (rx_cyc == FB * C - 1) begin
          rx_act = 1'b0;
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL rx_unexpected: got frame %0h, expected none", rx_bits[8:1]);
          end else begin
            exp_b = sb.pop_front();
            check("rx_byte", {24'h0, rx_bits[8:1]}, {24'h0, exp_b});
            check("rx_start", {31'h0, rx_bits[0]}, 32'h0);
            check("rx_stop", {31'h0, rx_bits[FB-1]}, 32'h1);
`ifdef CHIRP_UART_TX_PARITY_EN
            check("rx_parity", {31'h0, rx_bits[9]}, {31'h0, ^exp_b});
`endif
          end
        end
      end
    end
  end

  // 9600 bps receiver model for the slow instance.
  task automatic rx_slow(output logic [7:0] b);
    int w = 0;
    b = 8'h00;
    while (tx_slow !== 1'b0 && w < 30 * SLOW_C) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (tx_slow !== 1'b0) begin
      fail_now("rx_slow_start");
    end else begin
      #(BIT_NS / 2.0);
      check("slow_start", {31'h0, tx_slow}, 32'h0);
      for (int k = 0; k < 8; k++) begin
        #(BIT_NS);
        b[k] = tx_slow;
      end
`ifdef CHIRP_UART_TX_PARITY_EN
      #(BIT_NS);
      check("slow_parity", {31'h0, tx_slow}, {31'h0, ^b});
`endif
      #(BIT_NS);
      check("slow_stop", {31'h0, tx_slow}, 32'h1);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [8:0] head;  // start bit + data bits, transmission order from bit 0
    logic       par;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic       eb;
    logic       low_seen;
    logic [7:0] got;
    logic [7:0] slow_bytes[3];
    vecs[0] = '{8'hA5, 9'h14A, 1'b0};
    vecs[1] = '{8'h07, 9'h00E, 1'b1};
    vecs[2] = '{8'h03, 9'h006, 1'b0};
    vecs[3] = '{8'h00, 9'h000, 1'b0};
    vecs[4] = '{8'hFF, 9'h1FE, 1'b0};
    vecs[5] = '{8'h80, 9'h100, 1'b1};
    slow_bytes[0] = 8'h00;
    slow_bytes[1] = 8'h55;
    slow_bytes[2] = 8'hFF;

    #10 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h1);
    rst_n = 1'b1;  // first push is offered on the very next edge

    // Table: one frame at a time, every cycle of every bit compared.
    for (int i = 0; i < 6; i++) begin
      wait_idle(200);
      push(vecs[i].data);
      valid = 1'b0;
      check("pre_start_tx", {31'h0, tx}, 32'h1);
      for (int j = 0; j < FB; j++) begin
        if (j < 9) eb = vecs[i].head[j];
`ifdef CHIRP_UART_TX_PARITY_EN
        else if (j == 9) eb = vecs[i].par;
`endif
        else eb = 1'b1;
        for (int c = 0; c < C; c++) begin
          @(negedge clk);
          din = 8'($urandom);
          check($sformatf("v%0d_bit%0d_c%0d", i, j, c), {31'h0, tx}, {31'h0, eb});
        end
      end
      check("busy_in_stop", {31'h0, busy}, 32'h1);
      @(negedge clk);
      check("busy_after_stop", {31'h0, busy}, 32'h0);
      check("tx_after_stop", {31'h0, tx}, 32'h1);
    end

    // Back-to-back: the head is popped right away, so DEPTH+1 bytes fit
    // before o_ready drops; a further write while full must be dropped.
    wait_idle(200);
    frame_starts.delete();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    check("ready_after_4th", {31'h0, ready}, 32'h1);
    push(8'h05);
    check("ready_full", {31'h0, ready}, 32'h0);
    for (int r = 0; r < 3; r++) begin
      din = 8'hEE;
      valid = 1'b1;
      @(negedge clk);
      check("ready_full_hold", {31'h0, ready}, 32'h0);
    end
    push(8'h06);
    valid = 1'b0;
    wait_idle(1000);
    check("frames_seen", frame_starts.size(), 32'd6);
    for (int i = 1; i < frame_starts.size(); i++)
      check($sformatf("frame_gap%0d", i), frame_starts[i] - frame_starts[i-1], FB * C);

    // Reset in the middle of the 3rd data bit of 0xFF with two bytes queued.
    wait_idle(200);
    push(8'hFF);
    push(8'h11);
    push(8'h22);
    valid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("mid_frame_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", {31'h0, tx}, 32'h1);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_ready", {31'h0, ready}, 32'h1);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_seen = 1'b0;
    for (int c = 0; c < 3 * FB * C; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1'b1;
    end
    check("post_rst_line_idle", {31'h0, low_seen}, 32'h0);
    check("post_rst_busy", {31'h0, busy}, 32'h0);

    // Real bit rate on the slow instance.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      valid_slow = 1'b1;
      din_slow   = slow_bytes[i];
      @(negedge clk);
    end
    valid_slow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_slow(got);
      check($sformatf("slow_byte%0d", i), {24'h0, got}, {24'h0, slow_bytes[i]});
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time bound.
  initial begin
    #(10_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
